// File: rtl/pipeline_trace_monitor.sv
// pipeline_trace_monitor: commit trace buffer, cycle/instret counters and breakpoint/external halt control.
// Defining TRACE_CYCLE_STAMP_EN stores cycle_cnt with each entry and adds the rd_cycle_o read port.
module pipeline_trace_monitor #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int NUM_BP = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       commit_valid_i,
  input  logic [XLEN-1:0]            commit_pc_i,
  input  logic [31:0]                commit_instr_i,
  input  logic                       commit_rd_we_i,
  input  logic [4:0]                 commit_rd_addr_i,
  input  logic [XLEN-1:0]            commit_rd_data_i,
  input  logic [NUM_BP-1:0]          bp_en_i,
  input  logic [NUM_BP*XLEN-1:0]     bp_addr_i,
  input  logic                       halt_req_i,
  input  logic                       resume_i,
  output logic                       stall_o,
  output logic                       halted_o,
  output logic [1:0]                 halt_cause_o,
  input  logic                       rd_req_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
  output logic                       rd_valid_o,
  output logic [XLEN-1:0]            rd_pc_o,
  output logic [31:0]                rd_instr_o,
  output logic [4:0]                 rd_rd_addr_o,
  output logic [XLEN-1:0]            rd_rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [63:0]                cycle_cnt_o,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [63:0]                rd_cycle_o,
`endif
  output logic [63:0]                instret_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {RUN, HALTED} state_e;
  state_e state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, base, rd_ptr;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic [63:0] cycle_q, cycle_d, instret_q, instret_d;
  logic rd_valid_q, rd_valid_d;
  logic [XLEN-1:0] rd_pc_q, rd_pc_d, rd_data_q, rd_data_d;
  logic [31:0] rd_instr_q, rd_instr_d;
  logic [4:0] rd_addr_q, rd_addr_d;
  logic capture, bp_hit, rd_hit;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [4:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
`ifdef TRACE_CYCLE_STAMP_EN
  logic [63:0] cyc_mem [DEPTH];
  logic [63:0] rd_cycle_q, rd_cycle_d;
`endif
  always_comb begin
    bp_hit = 1'b0;
    for (int k = 0; k < NUM_BP; k++)
      bp_hit = bp_hit | (bp_en_i[k] && commit_pc_i == bp_addr_i[k*XLEN +: XLEN]);
    capture = state_q == RUN && commit_valid_i;
    // oldest entry sits count entries behind the write pointer
    base = wr_ptr_q - count_q[AW-1:0];
    rd_ptr = base + rd_idx_i;
    rd_hit = rd_req_i && {1'b0, rd_idx_i} < count_q;
    state_d = state_q;
    cause_d = cause_q;
    if (state_q == RUN && ((capture && bp_hit) || halt_req_i)) begin
      state_d = HALTED;
      cause_d = capture && bp_hit ? 2'd1 : 2'd2;
    end else if (state_q == HALTED && resume_i) begin
      state_d = RUN;
      cause_d = 2'd0;
    end
    wr_ptr_d = capture ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d = capture && count_q != FULL ? count_q + 1'b1 : count_q;
    overflow_d = overflow_q | (capture && count_q == FULL);
    instret_d = capture ? instret_q + 64'd1 : instret_q;
    cycle_d = state_q == RUN ? cycle_q + 64'd1 : cycle_q;
    rd_valid_d = rd_req_i;
    rd_pc_d = rd_hit ? pc_mem[rd_ptr] : '0;
    rd_instr_d = rd_hit ? instr_mem[rd_ptr] : '0;
    rd_addr_d = rd_hit ? addr_mem[rd_ptr] : '0;
    rd_data_d = rd_hit ? data_mem[rd_ptr] : '0;
`ifdef TRACE_CYCLE_STAMP_EN
    rd_cycle_d = rd_hit ? cyc_mem[rd_ptr] : '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cause_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      cycle_q <= '0;
      instret_q <= '0;
      rd_valid_q <= 1'b0;
      rd_pc_q <= '0;
      rd_instr_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
`ifdef TRACE_CYCLE_STAMP_EN
      rd_cycle_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      cycle_q <= cycle_d;
      instret_q <= instret_d;
      rd_valid_q <= rd_valid_d;
      rd_pc_q <= rd_pc_d;
      rd_instr_q <= rd_instr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
`ifdef TRACE_CYCLE_STAMP_EN
      rd_cycle_q <= rd_cycle_d;
`endif
    end
  end
  // writeback fields are zeroed at capture so reads need no we bit
  always_ff @(posedge clk) begin
    if (capture) begin
      pc_mem[wr_ptr_q] <= commit_pc_i;
      instr_mem[wr_ptr_q] <= commit_instr_i;
      addr_mem[wr_ptr_q] <= commit_rd_we_i ? commit_rd_addr_i : 5'd0;
      data_mem[wr_ptr_q] <= commit_rd_we_i ? commit_rd_data_i : '0;
`ifdef TRACE_CYCLE_STAMP_EN
      cyc_mem[wr_ptr_q] <= cycle_q;
`endif
    end
  end
  assign stall_o = state_q == HALTED;
  assign halted_o = state_q == HALTED;
  assign halt_cause_o = cause_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_pc_o = rd_pc_q;
  assign rd_instr_o = rd_instr_q;
  assign rd_rd_addr_o = rd_addr_q;
  assign rd_rd_data_o = rd_data_q;
  assign count_o = count_q;
  assign overflow_o = overflow_q;
  assign cycle_cnt_o = cycle_q;
  assign instret_o = instret_q;
`ifdef TRACE_CYCLE_STAMP_EN
  assign rd_cycle_o = rd_cycle_q;
`endif
endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// tb_pipeline_trace_monitor: directed plan scenarios plus random traffic against a queue-based trace model.
module tb_pipeline_trace_monitor;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cv = 1'b0, we = 1'b0, halt_req = 1'b0, resume = 1'b0, rd_req = 1'b0;
  logic [31:0] pc = '0, instr = '0, rdd = '0;
  logic [4:0] rda = '0;
  logic [1:0] bp_en = '0;
  logic [63:0] bp_addr = '0;
  logic [3:0] rd_idx = '0;
  logic stall_o, halted_o, rd_valid_o, overflow_o;
  logic [1:0] halt_cause_o;
  logic [31:0] rd_pc_o, rd_instr_o, rd_rd_data_o;
  logic [4:0] rd_rd_addr_o, count_o;
  logic [63:0] cycle_cnt_o, instret_o;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [63:0] rd_cycle_o;
`endif
  typedef struct {logic [31:0] pc, instr, data; logic [4:0] rd; logic [63:0] cyc;} ent_t;
  ent_t mq[$];
  ent_t exp_e;
  bit m_halt, m_ovf, exp_rv;
  int m_cause, n_chk = 0, n_err = 0;
  longint unsigned m_cycle, m_instret, frozen;

  pipeline_trace_monitor dut (
    .clk(clk), .rst_n(rst_n), .commit_valid_i(cv), .commit_pc_i(pc), .commit_instr_i(instr),
    .commit_rd_we_i(we), .commit_rd_addr_i(rda), .commit_rd_data_i(rdd), .bp_en_i(bp_en),
    .bp_addr_i(bp_addr), .halt_req_i(halt_req), .resume_i(resume), .stall_o(stall_o),
    .halted_o(halted_o), .halt_cause_o(halt_cause_o), .rd_req_i(rd_req), .rd_idx_i(rd_idx),
    .rd_valid_o(rd_valid_o), .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o),
    .rd_rd_addr_o(rd_rd_addr_o), .rd_rd_data_o(rd_rd_data_o), .count_o(count_o),
    .overflow_o(overflow_o), .cycle_cnt_o(cycle_cnt_o),
`ifdef TRACE_CYCLE_STAMP_EN
    .rd_cycle_o(rd_cycle_o),
`endif
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("stall", stall_o, m_halt);
    chk("halted", halted_o, m_halt);
    chk("cause", halt_cause_o, m_cause);
    chk("count", count_o, mq.size());
    chk("overflow", overflow_o, m_ovf);
    chk("cycle", cycle_cnt_o, m_cycle);
    chk("instret", instret_o, m_instret);
    chk("rd_valid", rd_valid_o, exp_rv);
    if (exp_rv) begin
      chk("rd_pc", rd_pc_o, exp_e.pc);
      chk("rd_instr", rd_instr_o, exp_e.instr);
      chk("rd_addr", rd_rd_addr_o, exp_e.rd);
      chk("rd_data", rd_rd_data_o, exp_e.data);
`ifdef TRACE_CYCLE_STAMP_EN
      chk("rd_cycle", rd_cycle_o, exp_e.cyc);
`endif
    end
  endtask

  task automatic tick();
    ent_t e;
    bit hit;
    exp_rv = rd_req;
    exp_e = '{default: 0};
    if (rd_req && int'(rd_idx) < mq.size()) exp_e = mq[rd_idx];
    if (!m_halt) begin
      hit = 0;
      for (int k = 0; k < 2; k++) if (cv && bp_en[k] && pc == bp_addr[k*32 +: 32]) hit = 1;
      if (cv) begin
        e.pc = pc; e.instr = instr; e.rd = we ? rda : 5'd0; e.data = we ? rdd : 32'd0; e.cyc = m_cycle;
        mq.push_back(e);
        if (mq.size() > 16) begin
          void'(mq.pop_front());
          m_ovf = 1;
        end
        m_instret++;
      end
      m_cycle++;
      if (hit) begin m_halt = 1; m_cause = 1; end
      else if (halt_req) begin m_halt = 1; m_cause = 2; end
    end else if (resume) begin
      m_halt = 0; m_cause = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cv = 0; we = 0; resume = 0; rd_req = 0; halt_req = 0;
  endtask

  task automatic commit(input logic [31:0] p);
    cv = 1; pc = p; instr = $urandom; we = 1; rda = 5'($urandom); rdd = $urandom;
    tick();
    cv = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    mq.delete(); m_halt = 0; m_cause = 0; m_ovf = 0; m_cycle = 0; m_instret = 0; exp_rv = 0;
    check_all();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic read(input int idx);
    rd_req = 1; rd_idx = 4'(idx);
    tick();
    rd_req = 0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 5; i++) commit(32'h1000 + 32'(i) * 4);
    do_reset();
    chk("rst_count", count_o, 0);
    chk("rst_instret", instret_o, 0);
    for (int i = 0; i < 20; i++) commit(32'(i) * 4);
    chk("wrap_count", count_o, 16);
    chk("wrap_ovf", overflow_o, 1);
    read(0);
    chk("wrap_idx0", rd_pc_o, 32'h10);
    read(15);
    chk("wrap_idx15", rd_pc_o, 32'h4C);
    do_reset();
    bp_en = 2'b01; bp_addr = {32'h0, 32'h20};
    for (int i = 0; i <= 8; i++) commit(32'(i) * 4);
    chk("bp_stall", stall_o, 1);
    chk("bp_cause", halt_cause_o, 1);
    commit(32'h24);
    chk("bp_instret", instret_o, 9);
    resume = 1; tick(); resume = 0;
    chk("bp_resume", stall_o, 0);
    for (int i = 10; i <= 12; i++) commit(32'(i) * 4);
    read(8);
    chk("bp_captured", rd_pc_o, 32'h20);
    bp_en = 0;
    do_reset();
    halt_req = 1;
    commit(32'h200);
    chk("ext_cause", halt_cause_o, 2);
    frozen = cycle_cnt_o;
    for (int i = 0; i < 10; i++) commit(32'h204);
    chk("cyc_frozen", cycle_cnt_o, frozen);
    resume = 1; tick(); resume = 0;
    chk("ext_run", halted_o, 0);
    tick();
    chk("ext_rehalt", halted_o, 1);
    halt_req = 0; resume = 1; tick(); resume = 0;
    do_reset();
    commit(32'h100);
    rd_req = 1; rd_idx = 0; cv = 1; pc = 32'h104; instr = 32'h02A00293; we = 1; rda = 5; rdd = 32'h2A;
    tick();
    idle();
    chk("same_cyc_pc", rd_pc_o, 32'h100);
    read(1);
    chk("reread_rd", rd_rd_addr_o, 5);
    chk("reread_data", rd_rd_data_o, 32'h2A);
    read(5);
    chk("oob_valid", rd_valid_o, 1);
    chk("oob_pc", rd_pc_o, 0);
`ifdef TRACE_CYCLE_STAMP_EN
    do_reset();
    repeat (3) tick();
    commit(32'h300);
    repeat (3) tick();
    commit(32'h304);
    read(0);
    chk("stamp0", rd_cycle_o, 3);
    read(1);
    chk("stamp1", rd_cycle_o, 7);
`endif
    do_reset();
    for (int b = 0; b < 20; b++) begin
      bp_en = 2'($urandom);
      bp_addr = {32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2};
      for (int i = 0; i < 100; i++) begin
        cv = 1'($urandom); pc = 32'($urandom_range(0, 15)) << 2; instr = $urandom;
        we = 1'($urandom); rda = 5'($urandom); rdd = $urandom;
        halt_req = $urandom_range(0, 19) == 0; resume = $urandom_range(0, 3) == 0;
        rd_req = 1'($urandom); rd_idx = 4'($urandom);
        tick();
      end
    end
    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
